// File: rtl/gray_counter.sv
// gray_counter: N-bit up/down Gray-code counter with Gray load, wrap/saturate mode and terminal-count flag
module gray_counter #(
  parameter int N    = 3,
  parameter bit WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up,
  input  logic         ld,
  input  logic [N-1:0] ld_g,
  output logic [N-1:0] g,
  output logic [N-1:0] b,
  output logic         tc
);
  logic [N-1:0] r_b, r_g, w_ld_b, w_nb;
  logic         r_tc, w_lim, w_tc;
  // decode the Gray load value, pick the next binary state and flag limit events
  always_comb begin
    w_ld_b = ld_g;
    for (int i = N - 2; i >= 0; i--) w_ld_b[i] = w_ld_b[i+1] ^ ld_g[i];
    w_lim = up ? &r_b : ~|r_b;
    w_tc  = !ld && en && w_lim;
    w_nb  = ld ? w_ld_b : (!en || (w_lim && !WRAP)) ? r_b : up ? r_b + 1'b1 : r_b - 1'b1;
  end
  // g is registered from the next binary value so it never glitches off a decode of b
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_b  <= '0;
      r_g  <= '0;
      r_tc <= 1'b0;
    end else begin
      r_b  <= w_nb;
      r_g  <= w_nb ^ (w_nb >> 1);
      r_tc <= w_tc;
    end
  assign b  = r_b;
  assign g  = r_g;
  assign tc = r_tc;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: randomized and directed checks of gray_counter against an arithmetic reference model
module tb_gray_counter;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, up = 1'b1, ld = 1'b0;
  logic [2:0] ld_g3 = '0;
  logic [7:0] ld_g8 = '0;
  logic [2:0] g_w, b_w, g_s, b_s;
  logic [7:0] g_8, b_8;
  logic       tc_w, tc_s, tc_8;
  int n_chk = 0, n_err = 0;
  int m_w = 0, m_s = 0, m_8 = 0;
  bit t_w = 0, t_s = 0, t_8 = 0;
  always #5 clk = ~clk;
  gray_counter #(.N(3), .WRAP(1'b1)) u_w (.clk(clk), .rst_n(rst_n), .en(en), .up(up), .ld(ld), .ld_g(ld_g3), .g(g_w), .b(b_w), .tc(tc_w));
  gray_counter #(.N(3), .WRAP(1'b0)) u_s (.clk(clk), .rst_n(rst_n), .en(en), .up(up), .ld(ld), .ld_g(ld_g3), .g(g_s), .b(b_s), .tc(tc_s));
  gray_counter #(.N(8), .WRAP(1'b1)) u_8 (.clk(clk), .rst_n(rst_n), .en(en), .up(up), .ld(ld), .ld_g(ld_g8), .g(g_8), .b(b_8), .tc(tc_8));
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask
  function automatic int gray(input int v);
    return v ^ (v >> 1);
  endfunction
  function automatic int ungray(input int gv, input int n);
    for (int x = 0; x < (1 << n); x++) if (gray(x) == gv) return x;
    return -1;
  endfunction
  task automatic mstep(input int n, input bit wr, input int gv, inout int v, output bit t);
    int mx = (1 << n) - 1;
    t = 1'b0;
    if (ld) v = ungray(gv, n);
    else if (en) begin
      if (up ? v == mx : v == 0) begin
        t = 1'b1;
        if (wr) v = up ? 0 : mx;
      end else v = up ? v + 1 : v - 1;
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, " b3w"}, int'(b_w), m_w);
    chk({tag, " g3w"}, int'(g_w), gray(m_w));
    chk({tag, " tc3w"}, int'(tc_w), int'(t_w));
    chk({tag, " b3s"}, int'(b_s), m_s);
    chk({tag, " g3s"}, int'(g_s), gray(m_s));
    chk({tag, " tc3s"}, int'(tc_s), int'(t_s));
    chk({tag, " b8"}, int'(b_8), m_8);
    chk({tag, " g8"}, int'(g_8), gray(m_8));
    chk({tag, " tc8"}, int'(tc_8), int'(t_8));
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    mstep(3, 1'b1, int'(ld_g3), m_w, t_w);
    mstep(3, 1'b0, int'(ld_g3), m_s, t_s);
    mstep(8, 1'b1, int'(ld_g8), m_8, t_8);
    #1;
    check_all(tag);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
  initial begin
    int seq[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
    int prev;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    step("idle");
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step("up");
      chk("t2 g", int'(g_w), seq[i]);
      chk("t2 tc", int'(tc_w), (i == 7) ? 1 : 0);
    end
    up = 1'b0;
    step("down");
    chk("t3 g", int'(g_w), 4);
    chk("t3 b", int'(b_w), 7);
    chk("t3 tc", int'(tc_w), 1);
    step("down");
    chk("t3 g2", int'(g_w), 5);
    chk("t3 b2", int'(b_w), 6);
    chk("t3 tc2", int'(tc_w), 0);
    ld = 1'b1;
    ld_g3 = 3'b110;
    ld_g8 = 8'h00;
    step("load");
    chk("t4 b", int'(b_w), 4);
    chk("t4 g", int'(g_w), 6);
    chk("t4 tc", int'(tc_w), 0);
    ld_g3 = 3'b100;
    en = 1'b0;
    step("ld7");
    ld = 1'b0;
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("sat");
      chk("t5 b", int'(b_s), 7);
      chk("t5 g", int'(g_s), 4);
      chk("t5 tc", int'(tc_s), 1);
    end
    ld = 1'b1;
    ld_g3 = 3'b111;
    en = 1'b0;
    step("ld5");
    ld = 1'b0;
    chk("t6 pre b", int'(b_w), 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_w = 0; m_s = 0; m_8 = 0;
    t_w = 0; t_s = 0; t_8 = 0;
    check_all("async");
    chk("t6 b", int'(b_w), 0);
    chk("t6 tc", int'(tc_w), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    up = 1'b1;
    prev = int'(g_8);
    for (int i = 0; i < 256; i++) begin
      step("n8");
      chk("n8 onebit", $countones(g_8 ^ prev[7:0]), 1);
      prev = int'(g_8);
    end
    for (int i = 0; i < 400; i++) begin
      en = $urandom_range(0, 3) != 0;
      up = 1'($urandom);
      ld = $urandom_range(0, 15) == 0;
      ld_g3 = 3'($urandom);
      ld_g8 = 8'($urandom);
      step("rand");
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
